// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Package : eth_pkg
// Brief   : Shared Ethernet framing constants, TX FSM state encoding and
//           CRC-32 helpers used by the GMII framer and the RX checker.
// Revision: 1.0 - initial release
// ============================================================================
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    PAD      = 3'd4,
    FCS      = 3'd5,
    IFG      = 3'd6
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam int          PREAMBLE_LEN  = 7;

  // The datapath shifts LSB first, so it needs the bit-mirrored polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module  : crc32_d8
// Brief   : Combinational one-byte update of the reflected IEEE 802.3 CRC-32.
// Revision: 1.0 - initial release
// ============================================================================
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  localparam logic [31:0] c_poly_rev = reflect32(CRC_POLY);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = crc_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[0] ? ((w_crc >> 1) ^ c_poly_rev) : (w_crc >> 1);
    end
    crc_out = w_crc;
  end

endmodule
`default_nettype wire

// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module  : gmii_tx_framer
// Brief   : Wraps a byte stream into a GMII frame: preamble, SFD, payload,
//           zero padding, FCS and inter-frame gap, with underrun signalling.
// Revision: 1.0 - initial release
// ============================================================================
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       gmii_txer
);

  tx_state_t   r_state, w_state_nxt;
  logic [31:0] r_step;
  logic [6:0]  r_count;
  logic [31:0] r_crc, w_crc_next, w_fcs;
  logic [7:0]  w_crc_byte, w_txd;
  logic        w_crc_en, w_count_inc, w_txen, w_txer;
  int          w_count_p1;

  assign s_ready    = (r_state == DATA) && !reset;
  assign w_fcs      = ~r_crc;
  assign w_count_p1 = int'({25'd0, r_count}) + 1;

  crc32_d8 u_crc (
    .crc_in  (r_crc),
    .d       (w_crc_byte),
    .crc_out (w_crc_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_txd       = 8'h00;
    w_txen      = 1'b0;
    w_txer      = 1'b0;
    w_crc_byte  = 8'h00;
    w_crc_en    = 1'b0;
    w_count_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid) w_state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        w_txd  = PREAMBLE_BYTE;
        w_txen = 1'b1;
        if (r_step == 32'(PREAMBLE_LEN - 1)) w_state_nxt = SFD;
      end
      SFD: begin
        w_txd       = SFD_BYTE;
        w_txen      = 1'b1;
        w_state_nxt = DATA;
      end
      DATA: begin
        w_txen = 1'b1;
        if (s_valid) begin
          w_txd       = s_data;
          w_crc_byte  = s_data;
          w_crc_en    = 1'b1;
          w_count_inc = 1'b1;
          if (s_last) w_state_nxt = (w_count_p1 < MIN_FRAME) ? PAD : FCS;
        end else begin
          w_txer      = 1'b1;
          w_state_nxt = IFG;
        end
      end
      PAD: begin
        w_txen      = 1'b1;
        w_crc_en    = 1'b1;
        w_count_inc = 1'b1;
        if (w_count_p1 >= MIN_FRAME) w_state_nxt = FCS;
      end
      FCS: begin
        w_txd  = w_fcs[{r_step[1:0], 3'b000} +: 8];
        w_txen = 1'b1;
        if (r_step == 32'd3) w_state_nxt = IFG;
      end
      IFG: begin
        // A waiting payload skips IDLE so the gap is exactly IFG_BYTES.
        if (r_step == 32'(IFG_BYTES - 1)) w_state_nxt = s_valid ? PREAMBLE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= 32'd0;
      r_count   <= 7'd0;
      r_crc     <= CRC_INIT;
      gmii_txd  <= 8'h00;
      gmii_txen <= 1'b0;
      gmii_txer <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= (w_state_nxt != r_state) ? 32'd0 : r_step + 32'd1;
      gmii_txd  <= w_txd;
      gmii_txen <= w_txen;
      gmii_txer <= w_txer;
      if (r_state == SFD) begin
        r_crc   <= CRC_INIT;
        r_count <= 7'd0;
      end else begin
        if (w_crc_en) r_crc <= w_crc_next;
        if (w_count_inc && r_count != 7'd127) r_count <= r_count + 7'd1;
      end
    end
  end

endmodule
`default_nettype wire
